mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: CPU data-memory responder. It serves reads and writes from an
// on-chip synchronous-read word RAM and one memory-mapped output register. A
// configurable number of wait states emulates slower external memory.
module mem_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 2,        // 0..15, counter is 4 bits
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic [15:0] rdata,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic [15:0] io_out
);

  localparam int          RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [16:0] RAM_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;     // request taken in IDLE on this edge
  logic        access;     // access performed on this edge
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic        hit_io;
  logic        hit_ram;
  logic        ram_we;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [15:0] ram_q;
  logic [15:0] mem [0:RAM_DEPTH-1];

  // Address decode on the latched address; the IO register wins over RAM.
  assign hit_io  = (addr_q == IO_ADDR);
  assign hit_ram = !hit_io && ({1'b0, addr_q} < RAM_WORDS);
  // A reset on the access edge must not commit the write.
  assign ram_we  = access && write_q && hit_ram && !rst;
  // Read the incoming address at acceptance, then keep re-reading the latched
  // one, so the RAM word is already registered when the access edge arrives.
  assign ram_raddr = (state == S_IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q[ADDR_WIDTH-1:0];

  // Next-state logic and per-edge control strobes.
  // NOTE: every output of this block is given a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ram_read || ram_write) begin
          accept     = 1'b1;
          cnt_next   = WAIT_CNT;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access     = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK:     state_next = S_RELEASE;
      S_RELEASE: if (!(ram_read || ram_write)) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State, request latch, registered handshake outputs, IO register and read data.
  // NOTE: sequential state uses non-blocking assignments, so every register samples
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mem_busy  <= 1'b0;
      mem_ready <= 1'b0;
      rdata     <= 16'h0000;
      io_out    <= 16'h0000;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      write_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mem_busy  <= (state_next == S_WAIT);
      mem_ready <= (state_next == S_ACK);
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= ram_write;   // a write wins when both request lines are high
      end
      if (access && write_q && hit_io) begin
        io_out <= wdata_q;
      end
      if (access && !write_q) begin
        rdata <= hit_io ? io_out : (hit_ram ? ram_q : 16'h0000);
      end
    end
  end

  // Word RAM with a registered read port, written on the access edge.
  // NOTE: the RAM array is deliberately left out of reset; a reset would stop it
  // mapping onto block RAM, and its power-up contents are undefined anyway.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[addr_q[ADDR_WIDTH-1:0]] <= wdata_q;
    end
    ram_q <= mem[ram_raddr];
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Instance 0 uses the
// default configuration (2 wait states, IO at FFFF). Instance 1 has no wait
// states and an IO address inside the RAM range. Expected read data comes from
// a reference model and goes through a scoreboard queue.
module tb_mem_responder;

  localparam int          WS0 = 2;
  localparam int          WS1 = 0;
  localparam logic [15:0] IO0 = 16'hFFFF;
  localparam logic [15:0] IO1 = 16'h0007;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr0, wdata0, rdata0, io0;
  logic        rd0, wr0, busy0, ready0;
  logic [15:0] addr1, wdata1, rdata1, io1;
  logic        rd1, wr1, busy1, ready1;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(WS0), .IO_ADDR(IO0)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .wdata(wdata0), .ram_read(rd0),
    .ram_write(wr0), .rdata(rdata0), .mem_busy(busy0), .mem_ready(ready0),
    .io_out(io0)
  );

  mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(WS1), .IO_ADDR(IO1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .wdata(wdata1), .ram_read(rd1),
    .ram_write(wr1), .rdata(rdata1), .mem_busy(busy1), .mem_ready(ready1),
    .io_out(io1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: RAM contents keyed by sel*65536+addr, IO register and last
  // read data for each instance.
  logic [15:0] mmem [int];
  logic [15:0] mio [2];
  logic [15:0] mrd [2];
  int          ws  [2];
  logic [15:0] ioa [2];
  logic [15:0] sb [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready0 : ready1;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic [15:0] get_io(input int sel);
    return (sel == 0) ? io0 : io1;
  endfunction

  function automatic logic [15:0] model_read(input int sel, input logic [15:0] a);
    int key;
    key = sel * 65536 + int'(a);
    if (a == ioa[sel]) return mio[sel];
    if (a < 16'h1000) return mmem.exists(key) ? mmem[key] : 16'hxxxx;
    return 16'h0000;
  endfunction

  // One complete transaction: update the model and push the expected rdata,
  // drive the request, watch busy/ready per cycle, drop the request in the
  // ready cycle and compare rdata there. A glitch changes addr/wdata after
  // acceptance.
  task automatic access(input string tag, input int sel, input logic w, input logic r,
                        input logic [15:0] a, input logic [15:0] d, input logic glitch);
    int          busy_n;
    int          ready_n;
    int          ready_at;
    int          overlap;
    logic [15:0] exp_v;
    if (w) begin
      exp_v = mrd[sel];
      if (a == ioa[sel]) mio[sel] = d;
      else if (a < 16'h1000) mmem[sel * 65536 + int'(a)] = d;
    end else begin
      exp_v = model_read(sel, a);
      mrd[sel] = exp_v;
    end
    sb.push_back(exp_v);
    busy_n = 0; ready_n = 0; ready_at = 0; overlap = 0;
    @(negedge clk);
    drive(sel, r, w, a, d);
    for (int k = 1; k <= ws[sel] + 6; k++) begin
      @(negedge clk);
      if (glitch && k == 1) drive(sel, r, w, a ^ 16'h0010, ~d);
      if (get_busy(sel)) busy_n++;
      if (get_busy(sel) && get_ready(sel)) overlap++;
      if (get_ready(sel)) begin
        ready_n++;
        if (ready_at == 0) ready_at = k;
        if (sb.size() > 0) check({tag, "_rdata"}, get_rdata(sel), sb.pop_front());
        drive(sel, 1'b0, 1'b0, a, d);
      end
    end
    drive(sel, 1'b0, 1'b0, a, d);
    check({tag, "_busy_cycles"}, 16'(busy_n), 16'(ws[sel] + 1));
    check({tag, "_ready_cycle"}, 16'(ready_at), 16'(ws[sel] + 2));
    check({tag, "_ready_pulses"}, 16'(ready_n), 16'd1);
    check({tag, "_busy_ready_overlap"}, 16'(overlap), 16'd0);
    check({tag, "_io_out"}, get_io(sel), mio[sel]);
    sb.delete();
  endtask

  initial begin
    int pulses;
    ws[0] = WS0; ws[1] = WS1;
    ioa[0] = IO0; ioa[1] = IO1;
    mio[0] = 16'h0000; mio[1] = 16'h0000;
    mrd[0] = 16'h0000; mrd[1] = 16'h0000;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check("reset_busy0", 16'(busy0), 16'd0);
    check("reset_ready0", 16'(ready0), 16'd0);
    check("reset_rdata0", rdata0, 16'h0000);
    check("reset_io0", io0, 16'h0000);
    check("reset_busy1", 16'(busy1), 16'd0);
    check("reset_rdata1", rdata1, 16'h0000);
    rst = 1'b0;

    // RAM write/read with two wait states.
    access("ram_wr", 0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
    access("ram_rd", 0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);

    // IO register, and the out-of-range address.
    access("io_wr", 0, 1'b1, 1'b0, 16'hFFFF, 16'h00A5, 1'b0);
    access("io_rd", 0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    access("oor_wr", 0, 1'b1, 1'b0, 16'h2000, 16'h7777, 1'b0);
    access("oor_rd", 0, 1'b0, 1'b1, 16'h2000, 16'h0000, 1'b0);

    // Reset held for two cycles during WAIT of a pending write to addr 5.
    access("pre_wr5", 0, 1'b1, 1'b0, 16'h0005, 16'h0055, 1'b0);
    access("pre_rd5", 0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0005, 16'hDEAD);
    @(negedge clk);
    check("mid_wait_busy", 16'(busy0), 16'd1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0005, 16'hDEAD);
    repeat (2) @(negedge clk);
    check("rst_wait_busy", 16'(busy0), 16'd0);
    check("rst_wait_ready", 16'(ready0), 16'd0);
    check("rst_wait_rdata", rdata0, 16'h0000);
    check("rst_wait_io", io0, 16'h0000);
    rst = 1'b0;
    mio[0] = 16'h0000; mio[1] = 16'h0000;
    mrd[0] = 16'h0000; mrd[1] = 16'h0000;
    access("post_rst_rd5", 0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0);
    access("post_rst_io_rd", 0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);

    // Read held for 20 cycles: exactly one ready pulse.
    mrd[0] = model_read(0, 16'h0010);
    sb.push_back(mrd[0]);
    pulses = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    repeat (20) begin
      @(negedge clk);
      if (ready0) begin
        pulses++;
        if (sb.size() > 0) check("held_rdata", rdata0, sb.pop_front());
      end
    end
    drive(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    sb.delete();
    check("held_pulses", 16'(pulses), 16'd1);
    access("rearm_rd", 0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);

    // Read and write together: treated as a write, rdata unchanged.
    access("both_req", 0, 1'b1, 1'b1, 16'h0003, 16'h1234, 1'b0);
    access("both_rd3", 0, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0);

    // No wait states, addr/wdata glitching after acceptance.
    access("ws0_wr30", 1, 1'b1, 1'b0, 16'h0030, 16'h5555, 1'b0);
    access("ws0_glitch_wr", 1, 1'b1, 1'b0, 16'h0020, 16'h4321, 1'b1);
    access("ws0_rd30", 1, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0);
    access("ws0_rd20", 1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);
    access("ws0_glitch_rd", 1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1);

    // IO address inside the RAM range takes precedence.
    access("io_prec_wr", 1, 1'b1, 1'b0, 16'h0007, 16'h0BAD, 1'b0);
    access("io_prec_rd", 1, 1'b0, 1'b1, 16'h0007, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
